// File: rtl/bp_cache_req_arbiter_pkg.sv
// Shared types and width helpers for the I$/D$ cache-request arbiter.
package bp_cache_req_arbiter_pkg;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg,
        e_bp_dual_core_cfg
    } bp_params_e;

    typedef enum logic [1:0] {
        e_idle,
        e_meta,
        e_busy
    } e_cache_req_arb_state;

    localparam int unsigned num_req_lp = 2;

    // Request packet: paddr + msg type (4) + size (3) + one dword of payload.
    function automatic int unsigned bp_cache_req_width(bp_params_e cfg);
        case (cfg)
            e_bp_dual_core_cfg: return 48 + 4 + 3 + 64;
            default:            return 40 + 4 + 3 + 64;
        endcase
    endfunction

    // Metadata: hit/replacement flag + way index + dirty bit.
    function automatic int unsigned bp_cache_req_metadata_width(bp_params_e cfg);
        case (cfg)
            e_bp_dual_core_cfg: return 1 + 2 + 1;
            default:            return 1 + 3 + 1;
        endcase
    endfunction

endpackage

// File: rtl/bp_cache_req_arbiter_rr.sv
// Two-input round-robin select with a lock that pins the choice while an
// offered request is waiting for the LCE to become ready.
module bp_cache_req_arbiter_rr
    import bp_cache_req_arbiter_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [num_req_lp-1:0] v_i,
    input  logic                  last_grant_i,
    input  logic                  hold_i,
    output logic                  sel_o
);

    logic rr_sel;
    logic lock_r;
    logic lock_sel_r;

    always_comb begin
        rr_sel = ~last_grant_i;
        if (v_i == 2'b01) begin
            rr_sel = 1'b0;
        end else if (v_i == 2'b10) begin
            rr_sel = 1'b1;
        end
    end

    // The lock only sticks while the locked requester keeps its valid up.
    assign sel_o = (lock_r && v_i[lock_sel_r]) ? lock_sel_r : rr_sel;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lock_r     <= 1'b0;
            lock_sel_r <= 1'b0;
        end else begin
            lock_r     <= hold_i;
            lock_sel_r <= sel_o;
        end
    end

endmodule

// File: rtl/bp_cache_req_arbiter.sv
// Shares one LCE cache-service request channel between I$ (0) and D$ (1),
// one miss at a time: request, metadata, then hold until LCE completion.
module bp_cache_req_arbiter
    import bp_cache_req_arbiter_pkg::*;
#(
    parameter bp_params_e  bp_params_p                 = e_bp_single_core_cfg,
    parameter int unsigned cache_req_width_lp          = bp_cache_req_width(bp_params_p),
    parameter int unsigned cache_req_metadata_width_lp = bp_cache_req_metadata_width(bp_params_p)
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    input  logic [num_req_lp-1:0][cache_req_width_lp-1:0]          cache_req_i,
    input  logic [num_req_lp-1:0]                                  cache_req_v_i,
    output logic [num_req_lp-1:0]                                  cache_req_ready_o,
    input  logic [num_req_lp-1:0][cache_req_metadata_width_lp-1:0] cache_req_metadata_i,
    input  logic [num_req_lp-1:0]                                  cache_req_metadata_v_i,
    output logic [num_req_lp-1:0]                                  cache_req_complete_o,
    output logic [cache_req_width_lp-1:0]                          lce_req_o,
    output logic                                                   lce_req_v_o,
    input  logic                                                   lce_req_ready_i,
    output logic [cache_req_metadata_width_lp-1:0]                 lce_req_metadata_o,
    output logic                                                   lce_req_metadata_v_o,
    input  logic                                                   lce_req_complete_i,
    output logic                                                   owner_o,
    output logic                                                   busy_o
);

    e_cache_req_arb_state state_r, state_n;
    logic owner_r, owner_n;
    logic last_grant_r, last_grant_n;
    logic sel;
    logic hold;
    logic accept;

    bp_cache_req_arbiter_rr rr (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .v_i          (cache_req_v_i),
        .last_grant_i (last_grant_r),
        .hold_i       (hold),
        .sel_o        (sel)
    );

    always_comb begin
        state_n              = state_r;
        owner_n              = owner_r;
        last_grant_n         = last_grant_r;
        cache_req_ready_o    = '0;
        cache_req_complete_o = '0;
        lce_req_o            = cache_req_i[sel];
        lce_req_v_o          = 1'b0;
        lce_req_metadata_o   = cache_req_metadata_i[owner_r];
        lce_req_metadata_v_o = 1'b0;
        hold                 = 1'b0;
        accept               = 1'b0;

        unique case (state_r)
            e_idle: begin
                lce_req_v_o            = |cache_req_v_i;
                cache_req_ready_o[sel] = lce_req_ready_i;
                lce_req_metadata_o     = cache_req_metadata_i[sel];
                accept                 = lce_req_v_o & lce_req_ready_i;
                hold                   = lce_req_v_o & ~lce_req_ready_i;
                if (accept) begin
                    owner_n              = sel;
                    last_grant_n         = sel;
                    // Metadata arriving with the request skips the metadata wait.
                    lce_req_metadata_v_o = cache_req_metadata_v_i[sel];
                    state_n              = lce_req_metadata_v_o ? e_busy : e_meta;
                end
            end
            e_meta: begin
                lce_req_metadata_v_o = cache_req_metadata_v_i[owner_r];
                if (lce_req_complete_i) begin
                    cache_req_complete_o[owner_r] = 1'b1;
                    state_n                       = e_idle;
                end else if (lce_req_metadata_v_o) begin
                    state_n = e_busy;
                end
            end
            e_busy: begin
                if (lce_req_complete_i) begin
                    cache_req_complete_o[owner_r] = 1'b1;
                    state_n                       = e_idle;
                end
            end
            default: state_n = e_idle;
        endcase

        if (reset_i) begin
            cache_req_ready_o    = '0;
            cache_req_complete_o = '0;
            lce_req_o            = '0;
            lce_req_v_o          = 1'b0;
            lce_req_metadata_o   = '0;
            lce_req_metadata_v_o = 1'b0;
            hold                 = 1'b0;
        end
    end

    assign busy_o  = (state_r != e_idle) & ~reset_i;
    assign owner_o = owner_r & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_n;
            owner_r      <= owner_n;
            last_grant_r <= last_grant_n;
        end
    end

    a_no_complete_in_idle: assert property (@(posedge clk_i) disable iff (reset_i)
        !(state_r == e_idle && lce_req_complete_i));

    a_sel_stable_while_offered: assert property (@(posedge clk_i) disable iff (reset_i)
        hold |=> (!cache_req_v_i[$past(sel)] || sel == $past(sel)));

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Self-checking bench for bp_cache_req_arbiter: directed scenarios plus
// randomized traffic, checked every cycle against a transaction-level model.
module tb_bp_cache_req_arbiter;
    import bp_cache_req_arbiter_pkg::*;

    localparam int unsigned rw_lp = bp_cache_req_width(e_bp_single_core_cfg);
    localparam int unsigned mw_lp = bp_cache_req_metadata_width(e_bp_single_core_cfg);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset;
    logic [1:0][rw_lp-1:0]      cache_req;
    logic [1:0]                 cache_req_v;
    logic [1:0]                 cache_req_ready;
    logic [1:0][mw_lp-1:0]      cache_req_metadata;
    logic [1:0]                 cache_req_metadata_v;
    logic [1:0]                 cache_req_complete;
    logic [rw_lp-1:0]           lce_req;
    logic                       lce_req_v;
    logic                       lce_req_ready;
    logic [mw_lp-1:0]           lce_req_metadata;
    logic                       lce_req_metadata_v;
    logic                       lce_req_complete;
    logic                       owner;
    logic                       busy;

    bp_cache_req_arbiter #(
        .bp_params_p (e_bp_single_core_cfg)
    ) dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .cache_req_i            (cache_req),
        .cache_req_v_i          (cache_req_v),
        .cache_req_ready_o      (cache_req_ready),
        .cache_req_metadata_i   (cache_req_metadata),
        .cache_req_metadata_v_i (cache_req_metadata_v),
        .cache_req_complete_o   (cache_req_complete),
        .lce_req_o              (lce_req),
        .lce_req_v_o            (lce_req_v),
        .lce_req_ready_i        (lce_req_ready),
        .lce_req_metadata_o     (lce_req_metadata),
        .lce_req_metadata_v_o   (lce_req_metadata_v),
        .lce_req_complete_i     (lce_req_complete),
        .owner_o                (owner),
        .busy_o                 (busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: 0 = channel free, 1 = granted and waiting for
    // metadata, 2 = waiting for the LCE to finish. m_pref wins the next tie.
    int unsigned m_phase;
    int unsigned m_owner;
    int unsigned m_pref;
    bit          m_offer_v;
    int unsigned m_offer_r;
    bit          acc_seen;
    int unsigned acc_r;

    task automatic model_reset();
        m_phase   = 0;
        m_owner   = 0;
        m_pref    = 0;
        m_offer_v = 1'b0;
        m_offer_r = 0;
    endtask

    // Called at posedge+1 with inputs already driven; checks mid-cycle,
    // advances the model, and returns at the next posedge+1.
    task automatic step();
        int unsigned sel;
        bit          any_v, acc, fwd, offer_n;
        logic [1:0]  exp_ready, exp_cmpl;
        #4;
        acc_seen = 1'b0;
        if (reset) begin
            check_eq("rst_ready", cache_req_ready, 2'b00);
            check_eq("rst_lce_v", lce_req_v, 1'b0);
            check_eq("rst_meta_v", lce_req_metadata_v, 1'b0);
            check_eq("rst_cmpl", cache_req_complete, 2'b00);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_owner", owner, 1'b0);
            model_reset();
        end else begin
            any_v = (cache_req_v != 2'b00);
            if (m_offer_v && cache_req_v[m_offer_r]) sel = m_offer_r;
            else if (cache_req_v == 2'b10)            sel = 1;
            else if (cache_req_v == 2'b01)            sel = 0;
            else                                      sel = m_pref;
            exp_ready = 2'b00;
            exp_cmpl  = 2'b00;
            acc       = 1'b0;
            fwd       = 1'b0;
            if (m_phase == 0) begin
                exp_ready[sel] = lce_req_ready;
                acc = any_v && lce_req_ready;
                fwd = acc && cache_req_metadata_v[sel];
            end else begin
                fwd = (m_phase == 1) && cache_req_metadata_v[m_owner];
                if (lce_req_complete) exp_cmpl[m_owner] = 1'b1;
            end
            check_eq("ready_o", cache_req_ready, exp_ready);
            check_eq("lce_req_v", lce_req_v, (m_phase == 0) && any_v);
            if ((m_phase == 0) && any_v) check_eq("lce_req", lce_req, cache_req[sel]);
            check_eq("meta_v", lce_req_metadata_v, fwd);
            if (fwd) check_eq("meta", lce_req_metadata,
                              cache_req_metadata[(m_phase == 0) ? sel : m_owner]);
            check_eq("complete", cache_req_complete, exp_cmpl);
            check_eq("busy", busy, m_phase != 0);
            check_eq("owner", owner, m_owner);

            offer_n = (m_phase == 0) && any_v && !lce_req_ready;
            if (acc) begin
                m_owner  = sel;
                m_pref   = 1 - sel;
                m_phase  = fwd ? 2 : 1;
                acc_seen = 1'b1;
                acc_r    = sel;
            end else if (m_phase != 0 && lce_req_complete) begin
                m_phase = 0;
            end else if (m_phase == 1 && fwd) begin
                m_phase = 2;
            end
            m_offer_v = offer_n;
            m_offer_r = sel;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] mv, input logic rdy, input logic cmpl);
        cache_req_v          = v;
        cache_req_metadata_v = mv;
        lce_req_ready        = rdy;
        lce_req_complete     = cmpl;
    endtask

    task automatic new_pkt(input int unsigned r);
        logic [127:0] w;
        logic [31:0]  m;
        w = {$urandom(), $urandom(), $urandom(), $urandom()};
        m = $urandom();
        cache_req[r]          = w[rw_lp-1:0];
        cache_req_metadata[r] = m[mw_lp-1:0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        step();
        reset = 1'b0;
    endtask

    int unsigned obs_grants[2];
    bit [1:0]    pend;

    initial begin
        reset              = 1'b1;
        cache_req          = '0;
        cache_req_metadata = '0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;

        // 1: lone I$ miss, metadata next cycle, completion pulse to I$
        do_reset();
        new_pkt(0); new_pkt(1);
        drive(2'b01, 2'b00, 1'b1, 1'b0); step();
        check_eq("t1_owner", owner, 1'b0);
        check_eq("t1_busy", busy, 1'b1);
        drive(2'b00, 2'b01, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();
        check_eq("t1_idle", busy, 1'b0);

        // 2: both requesting continuously alternate, I$ first
        do_reset();
        obs_grants[0] = 0;
        obs_grants[1] = 0;
        for (int rnd = 0; rnd < 8; rnd++) begin
            drive(2'b11, 2'b00, 1'b1, 1'b0); step();
            check_eq("t2_owner", owner, rnd % 2);
            obs_grants[owner]++;
            new_pkt(rnd % 2);
            drive(2'b11, (rnd % 2) ? 2'b10 : 2'b01, 1'b0, 1'b0); step();
            drive(2'b11, 2'b00, 1'b0, 1'b1); step();
        end
        check_eq("t2_grants_i", obs_grants[0], 4);
        check_eq("t2_grants_d", obs_grants[1], 4);

        // 3: D$ offered while LCE stalls; I$ arriving later must not steal it
        do_reset();
        new_pkt(0); new_pkt(1);
        drive(2'b10, 2'b00, 1'b0, 1'b0); step();
        drive(2'b11, 2'b00, 1'b0, 1'b0); step();
        drive(2'b11, 2'b00, 1'b0, 1'b0); step();
        drive(2'b11, 2'b00, 1'b1, 1'b0); step();
        check_eq("t3_owner", owner, 1'b1);
        drive(2'b00, 2'b10, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();

        // 4: non-owner metadata ignored in the metadata wait
        new_pkt(1);
        drive(2'b10, 2'b00, 1'b1, 1'b0); step();
        check_eq("t4_owner", owner, 1'b1);
        drive(2'b00, 2'b01, 1'b0, 1'b0); step();
        drive(2'b00, 2'b10, 1'b0, 1'b0); step();
        drive(2'b00, 2'b10, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();

        // 5: request and metadata together go straight to waiting on the LCE
        new_pkt(0);
        drive(2'b01, 2'b01, 1'b1, 1'b0); step();
        check_eq("t5_busy", busy, 1'b1);
        drive(2'b00, 2'b01, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();

        // 6: reset mid-miss drops the channel with no completion pulse
        new_pkt(1);
        drive(2'b10, 2'b10, 1'b1, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b0); step();
        reset = 1'b1;
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();
        reset = 1'b0;
        check_eq("t6_busy", busy, 1'b0);
        new_pkt(0);
        drive(2'b01, 2'b00, 1'b1, 1'b0); step();
        check_eq("t6_owner", owner, 1'b0);
        drive(2'b00, 2'b01, 1'b0, 1'b0); step();
        drive(2'b00, 2'b00, 1'b0, 1'b1); step();

        // Randomized traffic: requesters hold their packet until granted
        pend = 2'b00;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(3) == 0) begin
                    pend[r] = 1'b1;
                    new_pkt(r);
                end
                cache_req_v[r] = pend[r] && ($urandom_range(7) != 0);
            end
            cache_req_metadata_v = 2'($urandom_range(3));
            lce_req_ready        = 1'($urandom_range(1));
            lce_req_complete     = (m_phase != 0) && ($urandom_range(3) == 0);
            reset                = ($urandom_range(99) == 0);
            step();
            if (acc_seen) pend[acc_r] = 1'b0;
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
